// File: rtl/trap_ctrl.sv
// Trap initiator between commit and the CSR block: latches interrupt edges, takes the
// lowest-index pending interrupt at a boundary when MIE is set, and sequences mret.
// Optional feature macro: TRAP_VECTORED_EN (vectored mtvec mode when tvec_i[1:0]==2'b01).
`timescale 1ns/1ps

module trap_ctrl #(
    parameter int NUM_IRQ   = 4,
    parameter int CAUSE_OFS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    input  logic               inst_valid_i,
    input  logic [31:0]        pc_i,
    input  logic               mret_i,
    input  logic               mie_i,
    input  logic [31:0]        tvec_i,
    input  logic [31:0]        epc_i,
    output logic               save_epc_o,
    output logic [31:0]        trap_pc_o,
    output logic               mret_inst_o,
    output logic [31:0]        cause_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               stall_o
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAKE  = 2'd1,
        REDIR = 2'd2,
        RET   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        trap_pc_q, trap_pc_d;
    logic [31:0]        cause_q, cause_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic               save_epc_q, save_epc_d;
    logic               mret_q, mret_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               stall_q, stall_d;
    logic [IDX_W-1:0]   win_idx_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [31:0]        tgt_s;

    // Winner: scan from the top so the lowest set index is left standing.
    always_comb begin
        win_idx_s = {IDX_W{1'b0}};
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            win_idx_s = pending_q[k] ? IDX_W'(k) : win_idx_s;
        end
    end

    // Trap target for the REDIR cycle, formed while TAKE is active.
    always_comb begin
`ifdef TRAP_VECTORED_EN
        if (tvec_i[1:0] == 2'b01) begin
            tgt_s = (tvec_i & 32'hFFFF_FFFC) + ((32'(CAUSE_OFS) + 32'(idx_q)) << 2);
        end else begin
            tgt_s = tvec_i & 32'hFFFF_FFFC;
        end
`else
        tgt_s = tvec_i & 32'hFFFF_FFFC;
`endif
    end

    // Next state, pending bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        trap_pc_d = trap_pc_q;
        cause_d   = cause_q;
        clr_s     = {NUM_IRQ{1'b0}};
        case (state_q)
            IDLE: begin
                if (inst_valid_i && mret_i) begin
                    state_d = RET;
                end else if (inst_valid_i && mie_i && (|pending_q)) begin
                    state_d   = TAKE;
                    idx_d     = win_idx_s;
                    trap_pc_d = pc_i;
                    cause_d   = {1'b1, 31'(CAUSE_OFS) + 31'(win_idx_s)};
                end else begin
                    state_d = IDLE;
                end
            end
            TAKE: begin
                clr_s   = NUM_IRQ'(1) << idx_q;
                state_d = REDIR;
            end
            REDIR:   state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh edge in the ack cycle re-sets the bit after the clear.
        pending_d  = (pending_q & ~clr_s) | (irq_i & ~irq_prev_q);
        irq_prev_d = irq_i;

        save_epc_d = (state_d == TAKE);
        mret_d     = (state_d == RET);
        stall_d    = (state_d == TAKE) || (state_d == REDIR);
        redirect_d = (state_d == REDIR) || (state_d == RET);
        if (state_d == TAKE) begin
            ack_d = NUM_IRQ'(1) << idx_d;
        end else begin
            ack_d = {NUM_IRQ{1'b0}};
        end
        if (state_d == RET) begin
            redirect_pc_d = epc_i;
        end else if (state_d == REDIR) begin
            redirect_pc_d = tgt_s;
        end else begin
            redirect_pc_d = 32'h0000_0000;
        end
    end

    // State, pending and output registers; reset drops every pulse immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= {NUM_IRQ{1'b0}};
            irq_prev_q    <= {NUM_IRQ{1'b0}};
            idx_q         <= {IDX_W{1'b0}};
            trap_pc_q     <= 32'h0000_0000;
            cause_q       <= 32'h0000_0000;
            ack_q         <= {NUM_IRQ{1'b0}};
            save_epc_q    <= 1'b0;
            mret_q        <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            irq_prev_q    <= irq_prev_d;
            idx_q         <= idx_d;
            trap_pc_q     <= trap_pc_d;
            cause_q       <= cause_d;
            ack_q         <= ack_d;
            save_epc_q    <= save_epc_d;
            mret_q        <= mret_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            stall_q       <= stall_d;
        end
    end

    assign irq_ack_o     = ack_q;
    assign save_epc_o    = save_epc_q;
    assign trap_pc_o     = trap_pc_q;
    assign mret_inst_o   = mret_q;
    assign cause_o       = cause_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign stall_o       = stall_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl; vectored expectations follow TRAP_VECTORED_EN.
`timescale 1ns/1ps

module tb_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq = 4'b0000;
    logic [3:0]  ack;
    logic        iv = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        mret = 1'b0;
    logic        mie = 1'b0;
    logic [31:0] tvec = 32'h0000_0100;
    logic [31:0] epc = 32'h0;
    logic        save_epc;
    logic [31:0] trap_pc;
    logic        mret_inst;
    logic [31:0] cause;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    int          total = 0;
    int          bad = 0;

    trap_ctrl #(.NUM_IRQ(4), .CAUSE_OFS(16)) dut (
        .clk(clk), .rst(rst), .irq_i(irq), .irq_ack_o(ack),
        .inst_valid_i(iv), .pc_i(pc), .mret_i(mret), .mie_i(mie),
        .tvec_i(tvec), .epc_i(epc), .save_epc_o(save_epc), .trap_pc_o(trap_pc),
        .mret_inst_o(mret_inst), .cause_o(cause), .redirect_o(redirect),
        .redirect_pc_o(redirect_pc), .stall_o(stall)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc();
        total++; if (save_epc !== 1'b0) begin $display("FAIL rst_save got %b want 0", save_epc); bad++; end
        total++; if (redirect !== 1'b0) begin $display("FAIL rst_redirect got %b want 0", redirect); bad++; end
        total++; if (stall !== 1'b0) begin $display("FAIL rst_stall got %b want 0", stall); bad++; end
        total++; if (cause !== 32'h0) begin $display("FAIL rst_cause got %h want 0", cause); bad++; end
        total++; if (ack !== 4'b0000) begin $display("FAIL rst_ack got %b want 0000", ack); bad++; end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        mie = 1'b1; tvec = 32'h0000_0100; irq = 4'b0100;
        cyc();
        iv = 1'b1; pc = 32'h0000_0040;
        cyc();
        total++; if (save_epc !== 1'b1) begin $display("FAIL basic_save got %b want 1", save_epc); bad++; end
        total++; if (trap_pc !== 32'h40) begin $display("FAIL basic_trap_pc got %h want 40", trap_pc); bad++; end
        total++; if (ack !== 4'b0100) begin $display("FAIL basic_ack got %b want 0100", ack); bad++; end
        total++; if (cause !== 32'h8000_0012) begin $display("FAIL basic_cause got %h want 80000012", cause); bad++; end
        total++; if (stall !== 1'b1 || redirect !== 1'b0) begin $display("FAIL basic_take_stall got %b/%b want 1/0", stall, redirect); bad++; end
        iv = 1'b0; mie = 1'b0;
        cyc();
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin $display("FAIL basic_redir got %b/%h want 1/100", redirect, redirect_pc); bad++; end
        total++; if (save_epc !== 1'b0 || stall !== 1'b1) begin $display("FAIL basic_redir_ctl got %b/%b want 0/1", save_epc, stall); bad++; end
        cyc();
        total++; if (redirect !== 1'b0 || stall !== 1'b0) begin $display("FAIL basic_idle got %b/%b want 0/0", redirect, stall); bad++; end
        irq = 4'b0000;
        cyc();
    endtask

    task automatic test_priority();
        mie = 1'b1; irq = 4'b1010;
        cyc();
        iv = 1'b1; pc = 32'h0000_0080;
        cyc();
        total++; if (ack !== 4'b0010) begin $display("FAIL prio_first_ack got %b want 0010", ack); bad++; end
        total++; if (cause !== 32'h8000_0011) begin $display("FAIL prio_first_cause got %h want 80000011", cause); bad++; end
        iv = 1'b0; mie = 1'b0;
        cyc();
        cyc();
        iv = 1'b1; mret = 1'b1; epc = 32'h0000_0084;
        cyc();
        total++; if (mret_inst !== 1'b1 || redirect !== 1'b1) begin $display("FAIL prio_ret got %b/%b want 1/1", mret_inst, redirect); bad++; end
        total++; if (redirect_pc !== 32'h84 || save_epc !== 1'b0) begin $display("FAIL prio_ret_pc got %h/%b want 84/0", redirect_pc, save_epc); bad++; end
        iv = 1'b0; mret = 1'b0; mie = 1'b1;
        cyc();
        iv = 1'b1; pc = 32'h0000_0090;
        cyc();
        total++; if (ack !== 4'b1000 || save_epc !== 1'b1) begin $display("FAIL prio_second_ack got %b/%b want 1000/1", ack, save_epc); bad++; end
        total++; if (cause !== 32'h8000_0013) begin $display("FAIL prio_second_cause got %h want 80000013", cause); bad++; end
        iv = 1'b0; mie = 1'b0; irq = 4'b0000;
        cyc();
        cyc();
    endtask

    task automatic test_mie_hold();
        mie = 1'b0; irq = 4'b0001;
        cyc();
        irq = 4'b0000; iv = 1'b1; pc = 32'h0000_0050;
        cyc();
        total++; if (save_epc !== 1'b0 || stall !== 1'b0) begin $display("FAIL hold_masked got %b/%b want 0/0", save_epc, stall); bad++; end
        cyc();
        total++; if (save_epc !== 1'b0 || redirect !== 1'b0) begin $display("FAIL hold_masked2 got %b/%b want 0/0", save_epc, redirect); bad++; end
        mie = 1'b1;
        cyc();
        total++; if (save_epc !== 1'b1 || ack !== 4'b0001) begin $display("FAIL hold_take got %b/%b want 1/0001", save_epc, ack); bad++; end
        total++; if (cause !== 32'h8000_0010 || trap_pc !== 32'h50) begin $display("FAIL hold_cause got %h/%h want 80000010/50", cause, trap_pc); bad++; end
        iv = 1'b0; mie = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_mret_priority();
        irq = 4'b0100;
        cyc();
        mie = 1'b1; iv = 1'b1; mret = 1'b1; epc = 32'h0000_0200;
        cyc();
        total++; if (mret_inst !== 1'b1 || save_epc !== 1'b0) begin $display("FAIL mretp_ret got %b/%b want 1/0", mret_inst, save_epc); bad++; end
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin $display("FAIL mretp_redir got %b/%h want 1/200", redirect, redirect_pc); bad++; end
        total++; if (stall !== 1'b0) begin $display("FAIL mretp_stall got %b want 0", stall); bad++; end
        iv = 1'b0; mret = 1'b0;
        cyc();
        total++; if (mret_inst !== 1'b0 || redirect !== 1'b0) begin $display("FAIL mretp_idle got %b/%b want 0/0", mret_inst, redirect); bad++; end
        iv = 1'b1; pc = 32'h0000_0060;
        cyc();
        total++; if (save_epc !== 1'b1 || ack !== 4'b0100) begin $display("FAIL mretp_held got %b/%b want 1/0100", save_epc, ack); bad++; end
        iv = 1'b0; mie = 1'b0; irq = 4'b0000;
        cyc();
        cyc();
    endtask

    task automatic test_vectored();
        logic [31:0] exp_v;
`ifdef TRAP_VECTORED_EN
        exp_v = 32'h0000_0144;
`else
        exp_v = 32'h0000_0100;
`endif
        tvec = 32'h0000_0101; irq = 4'b0010;
        cyc();
        mie = 1'b1; iv = 1'b1; pc = 32'h0000_0070;
        cyc();
        iv = 1'b0; mie = 1'b0;
        cyc();
        total++; if (redirect !== 1'b1 || redirect_pc !== exp_v) begin $display("FAIL vec_mode1 got %b/%h want 1/%h", redirect, redirect_pc, exp_v); bad++; end
        irq = 4'b0000;
        cyc();
        tvec = 32'h0000_0100; irq = 4'b0010;
        cyc();
        mie = 1'b1; iv = 1'b1;
        cyc();
        iv = 1'b0; mie = 1'b0;
        cyc();
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin $display("FAIL vec_direct got %b/%h want 1/100", redirect, redirect_pc); bad++; end
        irq = 4'b0000;
        cyc();
    endtask

    task automatic test_reset_mid();
        irq = 4'b1001;
        cyc();
        mie = 1'b1; iv = 1'b1; pc = 32'h0000_00a0;
        cyc();
        iv = 1'b0; mie = 1'b0;
        cyc();
        total++; if (redirect !== 1'b1 || stall !== 1'b1) begin $display("FAIL rmid_pre got %b/%b want 1/1", redirect, stall); bad++; end
        #2 rst = 1'b1;
        #1;
        total++; if (redirect !== 1'b0 || stall !== 1'b0 || redirect_pc !== 32'h0) begin $display("FAIL rmid_drop got %b/%b/%h want 0/0/0", redirect, stall, redirect_pc); bad++; end
        irq = 4'b0000;
        cyc();
        rst = 1'b0;
        mie = 1'b1; iv = 1'b1;
        cyc();
        total++; if (save_epc !== 1'b0 || stall !== 1'b0) begin $display("FAIL rmid_pending_lost got %b/%b want 0/0", save_epc, stall); bad++; end
        iv = 1'b0; mie = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mie_hold();
        test_mret_priority();
        test_vectored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
